// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: decoupling FIFO between instruction fetch and ID.
// Buffers {pc, inst, taken, pht_index} entries. Flush discards everything in
// one cycle. When empty, the head outputs read as a zero NOP with zero PC.
// Optional feature: define IFQ_BYPASS_EN to let an offered entry reach the
// outputs in the same cycle when the queue is empty.
module inst_fetch_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned GHR_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         stall_next_stage,
  input  logic                         push_en,
  input  logic [31:0]                  pc_in,
  input  logic [31:0]                  inst_in,
  input  logic                         is_branch_taken_in,
  input  logic [GHR_WIDTH-1:0]         pht_index_in,
  output logic                         full,
  output logic                         valid_out,
  output logic [31:0]                  pc_out,
  output logic [31:0]                  inst_out,
  output logic                         is_branch_taken_out,
  output logic [GHR_WIDTH-1:0]         pht_index_out,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          inst;
    logic                 taken;
    logic [GHR_WIDTH-1:0] pht;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  entry_t w_in;
  entry_t w_head;
  logic   w_empty;
  logic   w_full;
  logic   w_byp_take;
  logic   w_push;
  logic   w_pop;

  assign w_in    = '{pc: pc_in, inst: inst_in, taken: is_branch_taken_in, pht: pht_index_in};
  assign w_head  = r_mem[r_rd_ptr];
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

`ifdef IFQ_BYPASS_EN
  // Entry offered into an empty queue and consumed by ID directly: never stored
  assign w_byp_take = w_empty && push_en && !flush && !stall_next_stage;
`else
  assign w_byp_take = 1'b0;
`endif

  // Full depends on count only, so a same-cycle pop never makes room
  assign w_push = push_en && !w_full && !flush && !w_byp_take;
  assign w_pop  = !w_empty && !stall_next_stage && !flush;

  // Pointer and occupancy tracking; flush dominates push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents survive flush and reset, only pointers are cleared
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in;
  end

  // Head presentation: stored head, optional same-cycle bypass, else zero NOP
  always_comb begin
    valid_out           = 1'b0;
    pc_out              = '0;
    inst_out            = '0;
    is_branch_taken_out = 1'b0;
    pht_index_out       = '0;
    if (!w_empty) begin
      valid_out           = 1'b1;
      pc_out              = w_head.pc;
      inst_out            = w_head.inst;
      is_branch_taken_out = w_head.taken;
      pht_index_out       = w_head.pht;
    end
`ifdef IFQ_BYPASS_EN
    else if (push_en && !flush) begin
      valid_out           = 1'b1;
      pc_out              = w_in.pc;
      inst_out            = w_in.inst;
      is_branch_taken_out = w_in.taken;
      pht_index_out       = w_in.pht;
    end
`endif
  end

  assign full  = w_full;
  assign count = r_count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue (DEPTH=8, GHR_WIDTH=5).
// A scoreboard queue holds expected entries in order; it is pushed when the
// stimulus offers an entry the queue should accept and popped when ID should
// consume the head. Honors IFQ_BYPASS_EN if defined for the build.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned GW    = 5;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          stall_next_stage;
  logic          push_en;
  logic [31:0]   pc_in;
  logic [31:0]   inst_in;
  logic          is_branch_taken_in;
  logic [GW-1:0] pht_index_in;
  logic          full;
  logic          valid_out;
  logic [31:0]   pc_out;
  logic [31:0]   inst_out;
  logic          is_branch_taken_out;
  logic [GW-1:0] pht_index_out;
  logic [3:0]    count;

  inst_fetch_queue #(.DEPTH(DEPTH), .GHR_WIDTH(GW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .stall_next_stage    (stall_next_stage),
    .push_en             (push_en),
    .pc_in               (pc_in),
    .inst_in             (inst_in),
    .is_branch_taken_in  (is_branch_taken_in),
    .pht_index_in        (pht_index_in),
    .full                (full),
    .valid_out           (valid_out),
    .pc_out              (pc_out),
    .inst_out            (inst_out),
    .is_branch_taken_out (is_branch_taken_out),
    .pht_index_out       (pht_index_out),
    .count               (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   pc;
    logic [31:0]   inst;
    logic          tk;
    logic [GW-1:0] pht;
  } ent_t;

  ent_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  // Single comparison point: counts and reports mismatches
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Outputs expected from the scoreboard state and the current inputs
  task automatic check_outputs(input string tag);
    ent_t e;
    logic v;
    e = '{pc: 32'h0, inst: 32'h0, tk: 1'b0, pht: '0};
    v = 1'b0;
    if (sb.size() != 0) begin
      e = sb[0];
      v = 1'b1;
    end else if (BYP && push_en && !flush) begin
      e = '{pc: pc_in, inst: inst_in, tk: is_branch_taken_in, pht: pht_index_in};
      v = 1'b1;
    end
    check_eq({tag, ".valid"}, 32'(valid_out), 32'(v));
    check_eq({tag, ".pc"},    pc_out, e.pc);
    check_eq({tag, ".inst"},  inst_out, e.inst);
    check_eq({tag, ".tk"},    32'(is_branch_taken_out), 32'(e.tk));
    check_eq({tag, ".pht"},   32'(pht_index_out), 32'(e.pht));
    check_eq({tag, ".count"}, 32'(count), 32'(sb.size()));
    check_eq({tag, ".full"},  32'(full), 32'(sb.size() == DEPTH));
  endtask

  // One clock cycle: drive, check at negedge, advance the scoreboard, edge
  task automatic step(input string tag, input logic pe, input logic [31:0] pc,
                      input logic [31:0] inst, input logic tk, input logic [GW-1:0] pht,
                      input logic st, input logic fl);
    bit was_full, was_empty;
    push_en = pe; pc_in = pc; inst_in = inst; is_branch_taken_in = tk;
    pht_index_in = pht; stall_next_stage = st; flush = fl;
    @(negedge clk);
    check_outputs(tag);
    was_full  = (sb.size() == DEPTH);
    was_empty = (sb.size() == 0);
    if (fl) begin
      sb.delete();
    end else begin
      if (!was_empty && !st) void'(sb.pop_front());
      if (pe && !was_full && !(BYP && was_empty && !st))
        sb.push_back('{pc: pc, inst: inst, tk: tk, pht: pht});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input int n, input logic st);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 32'h0, 32'h0, 1'b0, '0, st, 1'b0);
  endtask

  initial begin
    logic [31:0] pcs  [3];
    logic [31:0] insts[3];
    pcs[0] = 32'hbfc00000; pcs[1] = 32'hbfc00004; pcs[2] = 32'hbfc00008;
    insts[0] = 32'h90001234; insts[1] = 32'hac001234; insts[2] = 32'h0c123456;

    rst = 1'b1; flush = 1'b0; stall_next_stage = 1'b0; push_en = 1'b0;
    pc_in = '0; inst_in = '0; is_branch_taken_in = 1'b0; pht_index_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst_init");
    rst = 1'b0;
    idle("post_rst", 1, 1'b0);

    // In-order delivery, no stall
    for (int i = 0; i < 3; i++)
      step("inorder", 1'b1, pcs[i], insts[i], 1'(i), 5'(i + 3), 1'b0, 1'b0);
    idle("inorder_drain", 2, 1'b0);

    // Fill under stall, 9th push dropped, then drain
    for (int i = 0; i < 9; i++)
      step("fill", 1'b1, 32'hbfc00000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1'(i), 5'(i), 1'b1, 1'b0);
    idle("fill_hold", 1, 1'b1);
    idle("fill_drain", 10, 1'b0);

    // Wrap-around with three entries resident
    for (int i = 0; i < 3; i++)
      step("wrap_pre", 1'b1, 32'h8000_0000 + 32'(4 * i), 32'h2000_0000 + 32'(i), i[1], 5'(i * 7), 1'b1, 1'b0);
    for (int i = 3; i < 23; i++)
      step("wrap", 1'b1, 32'h8000_0000 + 32'(4 * i), 32'h2000_0000 + 32'(i), i[1], 5'(i * 7), 1'b0, 1'b0);
    idle("wrap_drain", 4, 1'b0);

    // Full queue: push and pop together -> push rejected
    for (int i = 0; i < 8; i++)
      step("sim_fill", 1'b1, 32'h9000_0000 + 32'(4 * i), 32'h3000_0000 + 32'(i), 1'b0, 5'(i), 1'b1, 1'b0);
    step("sim_pushpop", 1'b1, 32'h9000_0100, 32'h3000_00ff, 1'b1, 5'h1f, 1'b0, 1'b0);
    idle("sim_after", 1, 1'b1);

    // Flush with push and pop at count 5
    step("flush_clr", 1'b0, 32'h0, 32'h0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      step("fl_fill", 1'b1, 32'ha000_0000 + 32'(4 * i), 32'h4000_0000 + 32'(i), 1'b1, 5'(i), 1'b1, 1'b0);
    step("fl_all", 1'b1, 32'ha000_0100, 32'h4000_0100, 1'b1, 5'h11, 1'b0, 1'b1);
    step("fl_after_push", 1'b1, 32'ha000_0200, 32'h4000_0200, 1'b0, 5'h12, 1'b0, 1'b0);
    idle("fl_drain", 2, 1'b0);

    // Empty queue, push with no stall (same-cycle head when bypass is built in)
    step("bypass", 1'b1, 32'hbfc00010, 32'h14001234, 1'b0, 5'h05, 1'b0, 1'b0);
    idle("bypass_after", 2, 1'b0);

    // Asynchronous reset mid-run with three entries held
    for (int i = 0; i < 3; i++)
      step("rst_fill", 1'b1, 32'hc000_0000 + 32'(4 * i), 32'h5000_0000 + 32'(i), 1'b1, 5'(i + 1), 1'b1, 1'b0);
    push_en = 1'b0;
    check_eq("rst_pre.count", 32'(count), 32'd3);
    rst = 1'b1;
    #1;
    sb.delete();
    check_outputs("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle("rst_after", 2, 1'b0);
    step("rst_push", 1'b1, 32'hd000_0000, 32'h6000_0000, 1'b0, 5'h0a, 1'b0, 1'b0);
    idle("rst_push_drain", 2, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Decoupling FIFO between instruction fetch and the ID stage. Buffers fetched instructions together with their PC and branch-prediction tags (predicted-taken flag, PHT index), so fetch can run ahead while ID is stalled. On flush (branch mispredict or exception) all buffered entries are discarded in one cycle. Presents an `0x00000000` instruction (NOP) with zero PC to ID whenever it has nothing valid.

## Interface

Parameters:
- `DEPTH`, 8: number of entries; power of two, ≥ 2.
- `GHR_WIDTH`, 5: width of the PHT index, matching `GHR_BUS`.

Ports:
- `clk`, in, 1: clock. Everything is sampled on the rising edge.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `flush`, in, 1: discard all entries.
- `stall_next_stage`, in, 1: ID cannot accept an instruction this cycle.
- `push_en`, in, 1: fetch offers an entry.
- `pc_in`, in, 32: PC of the entry fetch is offering.
- `inst_in`, in, 32: instruction of the entry fetch is offering.
- `is_branch_taken_in`, in, 1: predictor's taken decision for the offered entry.
- `pht_index_in`, in, `GHR_WIDTH`: PHT index used for the offered entry's prediction.
- `full`, out, 1: queue cannot accept a push this cycle.
- `valid_out`, out, 1: the head entry is valid.
- `pc_out`, out, 32: PC of the head entry.
- `inst_out`, out, 32: instruction of the head entry.
- `is_branch_taken_out`, out, 1: taken flag of the head entry.
- `pht_index_out`, out, `GHR_WIDTH`: PHT index of the head entry.
- `count`, out, `$clog2(DEPTH+1)`: number of stored entries.

## Operation

- **Storage.** Circular buffer of `DEPTH` entries `{pc, inst, taken, pht_index}`. Read pointer `rd_ptr` and write pointer `wr_ptr` are each `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. `count` is tracked separately.
- **Full.** `full = (count == DEPTH)`, a function of `count` only. A pop in the same cycle does not make room for a push.
- **Push.** Accepted when `push_en && !full && !flush`. Writes the entry at `wr_ptr`, then `wr_ptr++`. A push while `full` is dropped silently; fetch must hold and retry.
- **Pop.** Occurs when `valid_out && !stall_next_stage && !flush`. Then `rd_ptr++`.
- **Simultaneous push and pop.** Both pointers advance and `count` is unchanged.
- **Head outputs.** Combinational from the head entry.
  - `valid_out = (count != 0)`.
  - When `count == 0`: `pc_out = 0`, `inst_out = 0`, `is_branch_taken_out = 0`, `pht_index_out = 0`.
- **Flush.** Highest priority. On the next edge `rd_ptr = wr_ptr = 0` and `count = 0`. A concurrent push or pop is ignored. Storage contents are not cleared.
- **Reset.** `rst` high asynchronously clears `rd_ptr`, `wr_ptr` and `count`. All outputs read 0 (`full = 0`, `valid_out = 0`, `count = 0`) while `rst` is high and until the first accepted push. A reset mid-operation loses all entries.

## Timing

- **Latency.** A push at edge N is visible on the outputs after edge N, i.e. in cycle N+1 (one cycle). The bypass option below changes this.
- **Head changes.** Head data updates only on an edge with a pop or flush, or when the queue goes from empty to non-empty.
- **Throughput.** One push and one pop per cycle sustained.
- **Flush.** Asserted in cycle N: `valid_out = 0` from cycle N+1. A push in cycle N+1 is accepted normally.
- **Stall.** `stall_next_stage` held: the head is stable and `count` grows until `full`.

## Configuration

Macro `IFQ_BYPASS_EN`.

When defined:
- If `count == 0 && push_en && !flush`, the outputs carry `pc_in`/`inst_in`/`is_branch_taken_in`/`pht_index_in` combinationally in the same cycle, with `valid_out = 1`.
- If `!stall_next_stage`, ID consumes the entry directly and it is not written (`count` stays 0).
- If stalled, the entry is written normally.

When not defined:
- Strict one-cycle latency as described in Timing.
- No combinational path from push inputs to outputs.

## Test plan

- **Reset.** Assert `rst` mid-run with `count = 3` → immediately `valid_out = 0`, `pc_out = 0`, `inst_out = 0`, `count = 0`, `full = 0`.
- **In-order delivery.** Push PCs `0xbfc00000`, `0xbfc00004`, `0xbfc00008` with insts `0x90001234`, `0xac001234`, `0x0c123456` and no stall → the same sequence appears on `pc_out`/`inst_out`, each one cycle after its push; `count` peaks at 1.
- **Fill under stall.** Hold `stall_next_stage = 1` and push 9 entries with `DEPTH = 8` → `full = 1` after the 8th; the 9th (`pc 0xbfc00020`) is dropped. Release stall → 8 entries drain in order, and `pc 0xbfc00020` never appears.
- **Wrap-around.** Run 20 push/pop cycles with `count` held at 3 → pointer wrap is transparent. Output PCs are strictly sequential and the `pht_index`/taken tags stay paired with their PCs.
- **Simultaneous events.** With the queue full, apply push and pop in the same cycle → push rejected, `count = 7`. With `flush` plus push plus pop in one cycle and `count = 5` → `count = 0` and `valid_out = 0` next cycle.
- **Bypass (only with `IFQ_BYPASS_EN`).** Queue empty, push `pc 0xbfc00010`, `inst 0x14001234`, no stall → `valid_out = 1` and `pc_out = 0xbfc00010` in the same cycle; `count` stays 0.
